// File: rtl/loop_nest_scheduler.sv
// Issues one iteration of a DIMS-deep loop nest every II enabled cycles; trips latched at start.
// Latency: first valid in the start cycle (0), then one issue per II enabled cycles; done 1 cycle after last.
// Backpressure: en_i low stalls the II counter and suppresses valid; LOOP_NEST_RESTART_EN lets start abort a running nest.
module loop_nest_scheduler #(
    parameter int DIMS = 2,
    parameter int W    = 16,
    parameter int II   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              en_i,
    input  logic [DIMS*W-1:0] trip_i,
    output logic              valid_o,
    output logic [DIMS*W-1:0] idx_o,
    output logic              last_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam int            CW      = (II > 1) ? $clog2(II) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(II - 1);

`ifdef LOOP_NEST_RESTART_EN
    localparam bit RESTART = 1'b1;
`else
    localparam bit RESTART = 1'b0;
`endif

    state_t                 state_q, state_d;
    logic [DIMS-1:0][W-1:0] trip_q, trip_d, idx_q, idx_d, trip_in, idx_step;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   accept, empty_in, all_one_in, step_last, carry;

    assign trip_in = trip_i;

    // Mixed-radix increment of the last issued index, dim 0 fastest.
    always_comb begin
        idx_step  = idx_q;
        carry     = 1'b1;
        step_last = 1'b1;
        for (int d = 0; d < DIMS; d++) begin
            if (carry) begin
                if (idx_q[d] == trip_q[d] - W'(1)) begin
                    idx_step[d] = '0;
                end else begin
                    idx_step[d] = idx_q[d] + W'(1);
                    carry       = 1'b0;
                end
            end
            if (idx_step[d] != trip_q[d] - W'(1))
                step_last = 1'b0;
        end
    end

    always_comb begin
        empty_in   = 1'b0;
        all_one_in = 1'b1;
        for (int d = 0; d < DIMS; d++) begin
            if (trip_in[d] == '0)
                empty_in = 1'b1;
            if (trip_in[d] != W'(1))
                all_one_in = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        trip_d  = trip_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        valid_o = 1'b0;
        last_o  = 1'b0;
        busy_o  = (state_q == S_RUN);
        done_o  = (state_q == S_DONE);
        accept  = start_i && ((state_q != S_RUN) || RESTART);

        if (state_q == S_DONE)
            state_d = S_IDLE;

        if (accept) begin
            trip_d = trip_in;
            cnt_d  = '0;
            if (empty_in) begin
                state_d = S_DONE;
            end else begin
                valid_o = 1'b1;
                last_o  = all_one_in;
                idx_d   = '0;
                state_d = all_one_in ? S_DONE : S_RUN;
            end
        end else if (state_q == S_RUN && en_i) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d   = '0;
                valid_o = 1'b1;
                last_o  = step_last;
                idx_d   = idx_step;
                if (step_last)
                    state_d = S_DONE;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        idx_o = idx_d;
        // Reset beats a same-cycle issue: nothing is reported as issued.
        if (rst) begin
            valid_o = 1'b0;
            last_o  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            trip_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            trip_q  <= trip_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_loop_nest_scheduler.sv
// Lockstep check of a 2-D II=1 scheduler and a 1-D II=3 scheduler against an
// enumeration model of the loop nest (iteration k -> mixed-radix digits of k).
module tb_loop_nest_scheduler;

    localparam int W = 16;
`ifdef LOOP_NEST_RESTART_EN
    localparam bit RESTART = 1'b1;
`else
    localparam bit RESTART = 1'b0;
`endif

    logic          clk, rst;
    logic          start_a, en_a, valid_a, last_a, busy_a, done_a;
    logic [2*W-1:0] trip_a, idx_a;
    logic          start_b, en_b, valid_b, last_b, busy_b, done_b;
    logic [W-1:0]  trip_b, idx_b;

    int n_chk  = 0;
    int n_pass = 0;

    loop_nest_scheduler #(.DIMS(2), .W(W), .II(1)) dut_a (
        .clk(clk), .rst(rst), .start_i(start_a), .en_i(en_a), .trip_i(trip_a),
        .valid_o(valid_a), .idx_o(idx_a), .last_o(last_a), .busy_o(busy_a), .done_o(done_a)
    );

    loop_nest_scheduler #(.DIMS(1), .W(W), .II(3)) dut_b (
        .clk(clk), .rst(rst), .start_i(start_b), .en_i(en_b), .trip_i(trip_b),
        .valid_o(valid_b), .idx_o(idx_b), .last_o(last_b), .busy_o(busy_b), .done_o(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state per unit (0 = 2-D II=1, 1 = 1-D II=3).
    int          m_nd[2] = '{2, 1};
    int          m_ii[2] = '{1, 3};
    int          m_tr0[2], m_tr1[2], m_tot[2], m_issued[2], m_ec[2];
    bit          m_run[2], m_done[2];
    logic [31:0] m_hold[2];

    task automatic chk(string tag, int u, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s unit%0d: got %0h expected %0h", tag, u, got, exp);
    endtask

    function automatic logic [31:0] tuple(int u, int k);
        int i0, i1;
        i0 = k % m_tr0[u];
        i1 = (k / m_tr0[u]) % m_tr1[u];
        return {i1[15:0], i0[15:0]};
    endfunction

    task automatic tick(bit r, bit sa, bit ea, int ta0, int ta1, bit sb, bit eb, int tb0);
        bit          v[2], l[2], acc[2], emp[2];
        int          k[2], n0[2], n1[2];
        logic [31:0] ei[2];
        logic [31:0] gv, gl, gb, gd, gi;
        rst = r; start_a = sa; en_a = ea; trip_a = {ta1[15:0], ta0[15:0]};
        start_b = sb; en_b = eb; trip_b = tb0[15:0];
        #3;
        for (int u = 0; u < 2; u++) begin
            bit s, e;
            s = (u == 0) ? sa : sb;
            e = (u == 0) ? ea : eb;
            n0[u] = (u == 0) ? ta0 : tb0;
            n1[u] = (m_nd[u] == 2) ? ta1 : 1;
            acc[u] = s && (!m_run[u] || RESTART);
            emp[u] = (n0[u] == 0) || (n1[u] == 0);
            v[u] = 1'b0; l[u] = 1'b0; k[u] = 0;
            if (acc[u]) begin
                if (!emp[u]) begin
                    v[u] = 1'b1;
                    l[u] = (n0[u] * n1[u] == 1);
                end
                ei[u] = v[u] ? 32'h0 : m_hold[u];
            end else begin
                if (m_run[u] && e && (m_ec[u] + 1 == m_ii[u])) begin
                    v[u] = 1'b1;
                    k[u] = m_issued[u];
                    l[u] = (k[u] == m_tot[u] - 1);
                end
                ei[u] = v[u] ? tuple(u, k[u]) : m_hold[u];
            end
            if (!r) begin
                gv = (u == 0) ? 32'(valid_a) : 32'(valid_b);
                gl = (u == 0) ? 32'(last_a)  : 32'(last_b);
                gb = (u == 0) ? 32'(busy_a)  : 32'(busy_b);
                gd = (u == 0) ? 32'(done_a)  : 32'(done_b);
                gi = (u == 0) ? idx_a : {16'h0, idx_b};
                chk("valid", u, gv, 32'(v[u]));
                chk("last",  u, gl, 32'(l[u]));
                chk("busy",  u, gb, 32'(m_run[u]));
                chk("done",  u, gd, 32'(m_done[u]));
                chk("idx",   u, gi, ei[u]);
            end
        end
        @(posedge clk);
        for (int u = 0; u < 2; u++) begin
            if (r) begin
                m_run[u] = 0; m_done[u] = 0; m_hold[u] = '0; m_ec[u] = 0; m_issued[u] = 0;
            end else begin
                m_done[u] = (v[u] && l[u]) || (acc[u] && emp[u]);
                if (acc[u]) begin
                    m_tr0[u] = n0[u]; m_tr1[u] = n1[u]; m_tot[u] = n0[u] * n1[u];
                    m_ec[u] = 0;
                    m_issued[u] = v[u] ? 1 : 0;
                    m_run[u] = !emp[u] && !l[u];
                end else begin
                    if (m_run[u] && ((u == 0) ? ea : eb))
                        m_ec[u] = v[u] ? 0 : m_ec[u] + 1;
                    if (v[u]) m_issued[u] = k[u] + 1;
                    if (v[u] && l[u]) m_run[u] = 0;
                end
                if (v[u]) m_hold[u] = ei[u];
            end
        end
        @(negedge clk);
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            m_tr0[u] = 1; m_tr1[u] = 1; m_tot[u] = 1;
        end
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 1, 7, 7, 0, 1, 7);
        // 2-D nest d1=3, d0=2 at II=1, alongside a 1-D trip 4 at II=3.
        tick(0, 1, 0, 2, 3, 1, 1, 4);
        for (int i = 0; i < 12; i++) tick(0, 0, 1, 9, 9, 0, 1, 9);
        // II=3 with en low for two cycles after the first issue.
        tick(0, 0, 1, 0, 0, 1, 1, 4);
        tick(0, 0, 1, 0, 0, 0, 0, 4);
        tick(0, 0, 1, 0, 0, 0, 0, 4);
        for (int i = 0; i < 12; i++) tick(0, 0, 1, 0, 0, 0, 1, 4);
        // Empty nest, then an all-ones nest.
        tick(0, 1, 1, 0, 5, 1, 1, 0);
        tick(0, 0, 1, 0, 5, 0, 1, 0);
        tick(0, 0, 1, 0, 0, 0, 1, 0);
        tick(0, 1, 1, 1, 1, 1, 1, 1);
        tick(0, 0, 1, 1, 1, 0, 1, 1);
        tick(0, 0, 1, 1, 1, 0, 1, 1);
        // Reset in the middle of a nest, then a clean restart.
        tick(0, 1, 1, 2, 3, 1, 1, 3);
        tick(0, 0, 1, 2, 3, 0, 1, 3);
        tick(0, 0, 1, 2, 3, 0, 1, 3);
        tick(1, 0, 1, 2, 3, 0, 1, 3);
        tick(0, 0, 1, 2, 3, 0, 1, 3);
        tick(0, 1, 1, 2, 3, 0, 1, 3);
        for (int i = 0; i < 7; i++) tick(0, 0, 1, 2, 3, 0, 1, 3);
        // Start while running, then back-to-back start in the done cycle.
        tick(0, 1, 1, 2, 3, 1, 1, 3);
        tick(0, 0, 1, 2, 3, 0, 1, 3);
        tick(0, 1, 1, 2, 3, 1, 1, 3);
        for (int i = 0; i < 12; i++) tick(0, 0, 1, 3, 1, 0, 1, 2);
        tick(0, 1, 1, 1, 2, 1, 1, 1);
        tick(0, 0, 1, 1, 2, 0, 1, 1);
        tick(0, 1, 1, 2, 1, 1, 1, 2);
        for (int i = 0; i < 8; i++) tick(0, 0, 1, 0, 0, 0, 1, 0);
        // Random starts, trips, stalls and occasional resets.
        for (int i = 0; i < 600; i++)
            tick($urandom_range(99) == 0,
                 $urandom_range(7) == 0, $urandom_range(3) != 0,
                 int'($urandom_range(3)), int'($urandom_range(3)),
                 $urandom_range(7) == 0, $urandom_range(3) != 0,
                 int'($urandom_range(5)));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
